// File: rtl/vga_register_panel.sv
// vga_register_panel: on-screen overlay that draws CHANNELS rows of WIDTH-bit register values
// as coloured bit cells. All channels are snapshotted at each frame start. A channel whose
// value changed at a frame start is highlighted for HOLD_FRAMES frames.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   data_in      packed register values, channel i = data_in[i*WIDTH +: WIDTH]
//   highlight_en enables change detection at frame start
//   vga_h/vga_v  current pixel position
//   pixel_out    RGB for the position presented two cycles earlier
//   display_on   pixel_out belongs to a cell (aligned with pixel_out)
//   frame_start  one-cycle registered pulse per detected frame start
module vga_register_panel #(
   parameter int unsigned CHANNELS    = 7,
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned START_H     = 50,
   parameter int unsigned START_V     = 10,
   parameter int unsigned ROW_PITCH   = 30,
   parameter int unsigned COL_PITCH   = 25,
   parameter int unsigned CELL_W      = 20,
   parameter int unsigned CELL_H      = 20,
   parameter int unsigned HOLD_FRAMES = 30,
   parameter logic [23:0] ON_COLOR    = 24'h00FF00,
   parameter logic [23:0] OFF_COLOR   = 24'h003300,
   parameter logic [23:0] HL_COLOR    = 24'hFF0000,
   parameter logic [23:0] BG_COLOR    = 24'h000000
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [CHANNELS*WIDTH-1:0] data_in,
   input  logic                      highlight_en,
   input  logic [10:0]               vga_h,
   input  logic [10:0]               vga_v,
   output logic [23:0]               pixel_out,
   output logic                      display_on,
   output logic                      frame_start
);

   localparam int unsigned CNT_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
   localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_FRAMES);

   // Half-open range test in 32 bits; positions are at most 2047, so any cell reaching past
   // the 11-bit screen is clipped naturally.
   function automatic logic in_range(input logic [10:0] p, input int unsigned lo,
                                     input int unsigned len);
      int unsigned pw;
      pw = {21'd0, p};
      return (pw >= lo) && (pw < lo + len);
   endfunction

   logic [10:0]                         pos_h_q, pos_v_q;
   logic                                frame_start_q;
   logic [CHANNELS-1:0][WIDTH-1:0]      snap_q, prev_q;
   logic [CHANNELS-1:0][CNT_W-1:0]      cnt_q;
   logic                                hit1_q, hit1_d;
   logic [CH_W-1:0]                     ch1_q, ch1_d;
   logic [BIT_W-1:0]                    bit1_q, bit1_d;
   logic [23:0]                         pixel_q, pixel_d;
   logic                                disp_q;
   logic                                fs_det;
   logic [WIDTH-1:0]                    row_bits;
   logic                                row_hl;
   logic                                cell_bit;

   // A frame start is the first cycle at (0, 0); holding (0, 0) does not retrigger.
   assign fs_det = (vga_h == 11'd0) && (vga_v == 11'd0) &&
                   !((pos_h_q == 11'd0) && (pos_v_q == 11'd0));

   // Stage 1 hit decode. Rows are scanned from the highest index down so the lowest
   // overlapping channel overwrites and wins.
   always_comb begin
      hit1_d = 1'b0;
      ch1_d  = '0;
      bit1_d = '0;
      for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
         if (in_range(vga_v, START_V + i * ROW_PITCH, CELL_H)) begin
            for (int j = 0; j < int'(WIDTH); j++) begin
               if (in_range(vga_h, START_H + j * COL_PITCH, CELL_W)) begin
                  hit1_d = 1'b1;
                  ch1_d  = CH_W'(i);
                  bit1_d = BIT_W'(int'(WIDTH) - 1 - j);
               end
            end
         end
      end
   end

   // Stage 2 colour lookup against the snapshot and highlight state of this cycle.
   always_comb begin
      row_bits = '0;
      row_hl   = 1'b0;
      cell_bit = 1'b0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         if (ch1_q == CH_W'(i)) begin
            row_bits = snap_q[i];
            row_hl   = (cnt_q[i] != '0);
         end
      end
      for (int j = 0; j < int'(WIDTH); j++) begin
         if (bit1_q == BIT_W'(j)) cell_bit = row_bits[j];
      end
      if (!hit1_q)       pixel_d = BG_COLOR;
      else if (!cell_bit) pixel_d = OFF_COLOR;
      else if (row_hl)    pixel_d = HL_COLOR;
      else                pixel_d = ON_COLOR;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pos_h_q       <= 11'h7FF;
         pos_v_q       <= 11'h7FF;
         frame_start_q <= 1'b0;
         snap_q        <= '0;
         prev_q        <= '0;
         cnt_q         <= '0;
         hit1_q        <= 1'b0;
         ch1_q         <= '0;
         bit1_q        <= '0;
         pixel_q       <= '0;
         disp_q        <= 1'b0;
      end else begin
         pos_h_q       <= vga_h;
         pos_v_q       <= vga_v;
         frame_start_q <= fs_det;
         hit1_q        <= hit1_d;
         ch1_q         <= ch1_d;
         bit1_q        <= bit1_d;
         pixel_q       <= pixel_d;
         disp_q        <= hit1_q;
         if (fs_det) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
               snap_q[i] <= data_in[i*WIDTH +: WIDTH];
               prev_q[i] <= snap_q[i];
               // Compare against the outgoing snapshot; countdown continues even when
               // highlight_en is low.
               if (highlight_en && (data_in[i*WIDTH +: WIDTH] != snap_q[i])) begin
                  cnt_q[i] <= HOLD_LOAD;
               end else if (cnt_q[i] != '0) begin
                  cnt_q[i] <= cnt_q[i] - 1'b1;
               end
            end
         end
      end
   end

   assign pixel_out   = pixel_q;
   assign display_on  = disp_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_register_panel.sv
// Directed bench for vga_register_panel: a default instance plus a HOLD_FRAMES = 0 instance
// sharing all inputs.
module tb_vga_register_panel;

   localparam logic [23:0] ON  = 24'h00FF00;
   localparam logic [23:0] OFF = 24'h003300;
   localparam logic [23:0] HL  = 24'hFF0000;
   localparam logic [23:0] BG  = 24'h000000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [55:0] data_in;
   logic        highlight_en;
   logic [10:0] vga_h, vga_v;
   logic [23:0] pixel_out, pixel_out0;
   logic        display_on, display_on0;
   logic        frame_start, frame_start0;

   int tests = 0;
   int fails = 0;
   int n_fs;

   always #5 clk = ~clk;

   vga_register_panel dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .data_in      (data_in),
      .highlight_en (highlight_en),
      .vga_h        (vga_h),
      .vga_v        (vga_v),
      .pixel_out    (pixel_out),
      .display_on   (display_on),
      .frame_start  (frame_start)
   );

   vga_register_panel #(.HOLD_FRAMES(0)) dut0 (
      .clk          (clk),
      .reset_n      (reset_n),
      .data_in      (data_in),
      .highlight_en (highlight_en),
      .vga_h        (vga_h),
      .vga_v        (vga_v),
      .pixel_out    (pixel_out0),
      .display_on   (display_on0),
      .frame_start  (frame_start0)
   );

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a position, wait out the 2-cycle latency, check the default instance.
   task automatic pix(input string tag, input int h, input int v, input logic [23:0] c,
                      input logic on);
      @(negedge clk);
      vga_h = 11'(h);
      vga_v = 11'(v);
      @(negedge clk);
      @(negedge clk);
      chk({tag, "_rgb"}, pixel_out, c);
      chk({tag, "_on"}, {23'd0, display_on}, {23'd0, on});
   endtask

   task automatic frame();
      @(negedge clk);
      vga_h = 11'd0;
      vga_v = 11'd0;
      @(negedge clk);
      vga_h = 11'd1;
      vga_v = 11'd1;
   endtask

   initial begin
      reset_n      = 1'b0;
      data_in      = '0;
      highlight_en = 1'b0;
      vga_h        = 11'd1;
      vga_v        = 11'd1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_pixel", pixel_out, 24'd0);
      chk("rst_on", {23'd0, display_on}, 24'd0);
      chk("rst_fs", {23'd0, frame_start}, 24'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Basic colours, highlighting off.
      data_in[0*8 +: 8] = 8'h01;
      data_in[1*8 +: 8] = 8'hA5;
      data_in[6*8 +: 8] = 8'h80;
      @(negedge clk);
      vga_h = 11'd0;
      vga_v = 11'd0;
      @(negedge clk);
      chk("fs_pulse", {23'd0, frame_start}, 24'd1);
      vga_h = 11'd1;
      vga_v = 11'd1;
      @(negedge clk);
      chk("fs_clear", {23'd0, frame_start}, 24'd0);
      pix("row1_msb", 50, 40, ON, 1'b1);
      pix("row1_bit6", 75, 40, OFF, 1'b1);
      pix("row1_gap", 70, 40, BG, 1'b0);

      // Cell and row boundaries.
      pix("row0_bit0_in", 244, 10, ON, 1'b1);
      pix("row0_bit0_out", 245, 10, BG, 1'b0);
      pix("row6_bot_in", 50, 209, ON, 1'b1);
      pix("row6_bot_out", 50, 210, BG, 1'b0);

      // Mid-frame data change is invisible until the next frame start.
      @(negedge clk);
      vga_h = 11'd5;
      vga_v = 11'd100;
      data_in[0*8 +: 8] = 8'h03;
      pix("mid_old", 219, 10, OFF, 1'b1);
      @(negedge clk);
      vga_h = 11'd0;
      vga_v = 11'd0;
      n_fs = 0;
      repeat (3) begin
         @(negedge clk);
         n_fs += int'(frame_start);
      end
      vga_h = 11'd1;
      vga_v = 11'd1;
      repeat (2) begin
         @(negedge clk);
         n_fs += int'(frame_start);
      end
      chk("held_00_pulses", 24'(n_fs), 24'd1);
      pix("mid_new", 219, 10, ON, 1'b1);

      // Channel 2 changes with highlighting off; channel 3 changes with it on.
      data_in[2*8 +: 8] = 8'hFF;
      frame();
      highlight_en = 1'b1;
      data_in[3*8 +: 8] = 8'hFF;
      frame();
      pix("hl_f1", 50, 100, HL, 1'b1);
      pix("hl_f1_b6", 75, 100, HL, 1'b1);
      pix("ch2_f1", 50, 70, ON, 1'b1);
      @(negedge clk);
      vga_h = 11'd50;
      vga_v = 11'd100;
      @(negedge clk);
      @(negedge clk);
      chk("hold0_rgb", pixel_out0, ON);
      chk("hold0_on", {23'd0, display_on0}, 24'd1);
      repeat (29) frame();
      pix("hl_f30", 50, 100, HL, 1'b1);
      pix("ch2_f30", 50, 70, ON, 1'b1);
      frame();
      pix("hl_f31", 50, 100, ON, 1'b1);

      // Reset while a hold is running.
      data_in[4*8 +: 8] = 8'hF0;
      frame();
      pix("ch4_hl", 50, 130, HL, 1'b1);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("arst_pixel", pixel_out, 24'd0);
      chk("arst_on", {23'd0, display_on}, 24'd0);
      chk("arst_fs", {23'd0, frame_start}, 24'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      vga_h = 11'd0;
      vga_v = 11'd0;
      @(negedge clk);
      chk("post_rst_fs", {23'd0, frame_start}, 24'd1);
      vga_h = 11'd1;
      vga_v = 11'd1;
      pix("post_rst_ch4", 50, 130, HL, 1'b1);
      pix("post_rst_ch1", 50, 40, HL, 1'b1);

      // Same reset with highlighting off: no highlight restarts.
      highlight_en = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      frame();
      pix("post_rst_nohl", 50, 130, ON, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
